// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI slave types, command codes and default widths
package spi_pkg;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  // Command codes carried in frame bits [9:8]; passed to the RAM verbatim.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - load/shift register driving MISO MSB first
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   clear       abort any shift in progress, MISO back to 0 next cycle
//   load        capture load_data; MISO shows bit DATA_W-1 the next cycle
//   load_data   word to serialise
//   miso        registered serial output, 0 when idle
//   busy        high while a word is being shifted out
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              miso,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;

  // MISO itself holds the current bit; sh holds the bits still to come and
  // cnt counts them, so the word appears on DATA_W consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      miso <= 1'b0;
      busy <= 1'b0;
    end else if (load) begin
      miso <= load_data[DATA_W-1];
      sh   <= {load_data[DATA_W-2:0], 1'b0};
      cnt  <= CNT_W'(DATA_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        miso <= 1'b0;
        busy <= 1'b0;
      end else begin
        miso <= sh[DATA_W-1];
        sh   <= {sh[DATA_W-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end: MOSI frames to RAM words, RAM read data to MISO
// Ports:
//   clk, rst_n  system clock (posedge), asynchronous active-low reset
//   frame_err   (only with SPI_FRAME_ERR_EN) one-cycle pulse on an aborted frame or shift-out
//   SS_n        slave select, active low; rising edge ends/aborts a frame
//   MOSI        serial data in, MSB first
//   MISO        serial data out, MSB first, registered
//   rx_data     last complete frame, held between rx_valid pulses
//   rx_valid    one-cycle pulse when rx_data holds a new frame
//   tx_data     RAM read data
//   tx_valid    RAM read data valid
// Optional feature macro: SPI_FRAME_ERR_EN
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int FRAME_W = SPI_FRAME_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SPI_FRAME_ERR_EN
  output logic               frame_err,
`endif
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam int                CNT_W     = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_W - 1);

  state_t             state, state_nxt;
  logic [FRAME_W-2:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               rd_addr_ok;
  logic               tx_done;
  logic               frame_done;
  logic               receiving;
  logic               capture;
  logic               ser_busy;

  assign frame_done = (bit_cnt == FRAME_CNT);
  assign receiving  = (state inside {WRITE, READ_ADD, READ_DATA}) && !frame_done;
  // Only the first tx_valid after a completed read-data frame is taken.
  assign capture    = (state == READ_DATA) && frame_done && !tx_done && tx_valid && !SS_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)           state_nxt = WRITE;
          else if (rd_addr_ok) state_nxt = READ_DATA;
          else                 state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Frame assembly. A deasserted SS_n wins over everything, so a partial
  // frame never reaches rx_data and rd_addr_ok keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rd_addr_ok <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        shift_q <= '0;
        bit_cnt <= '0;
        tx_done <= 1'b0;
      end else if (state == CHK_CMD) begin
        shift_q <= {{(FRAME_W-2){1'b0}}, MOSI};
        bit_cnt <= CNT_W'(1);
        tx_done <= 1'b0;
      end else if (receiving) begin
        shift_q <= {shift_q[FRAME_W-3:0], MOSI};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == LAST_CNT) begin
          rx_data  <= {shift_q, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD) rd_addr_ok <= 1'b1;
        end
      end else if (capture) begin
        tx_done    <= 1'b1;
        rd_addr_ok <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(.DATA_W(DATA_W)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (SS_n),
    .load      (capture),
    .load_data (tx_data),
    .miso      (MISO),
    .busy      (ser_busy)
  );

`ifdef SPI_FRAME_ERR_EN
  // Abort is an error only once the command bit is in and the frame is
  // still incomplete, or while read data is still going out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= SS_n && (receiving || ser_busy);
  end
`endif

endmodule
